// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padding constants, word/block types, padder FSM states.
// Latency: none (types and constants only).
// Backpressure: n/a.
package sha256_pkg;

    localparam logic [31:0] SHA256_PAD_WORD    = 32'h8000_0000;
    localparam int          SHA256_BLOCK_WORDS = 16;
    localparam int          SHA256_BLOCK_BITS  = 512;

    typedef logic [31:0]                    word_t;
    typedef logic [SHA256_BLOCK_BITS-1:0]   block_t;

    typedef enum logic [1:0] {
        PAD_IDLE,
        PAD_FILL,
        PAD_OFFER,
        PAD_DONE
    } pad_state_t;

endpackage

// File: rtl/sha256_msg_padder.sv
// Reads a NUM_OF_WORDS message from word memory, appends SHA-256 padding, emits 512-bit blocks.
// Latency: 17 cycles of fill per block, first blk_valid 17 cycles after start is accepted.
// Backpressure: block held stable in OFFER until blk_ready; nothing is refetched or lost.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         busy,
    output logic         done,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_last,
    output logic [7:0]   blk_index
);

    localparam int    BLOCKS      = ((NUM_OF_WORDS + 2) / 16) + 1;
    localparam int    TOTAL_WORDS = BLOCKS * SHA256_BLOCK_WORDS;
    localparam word_t LEN_WORD    = word_t'(NUM_OF_WORDS * 32);

    pad_state_t  state_q;
    pad_state_t  state_d;
    logic [15:0] base_q;
    logic [15:0] blk_q;
    logic [4:0]  k_q;

    logic [31:0] cur_idx;
    logic [31:0] wr_idx;
    logic [31:0] nxt_idx;
    logic [15:0] blk_inc;
    logic [31:0] nxt_blk_idx;
    logic [3:0]  wr_slot;
    logic [8:0]  wr_pos;
    logic        is_last;
    logic        handshake;
    logic        fill_end;

    // Slot content: message word, the pad marker, the length word, or zero fill
    // (the length high word is always zero for legal message sizes).
    function automatic word_t slot_word(input logic [31:0] idx, input word_t rd);
        word_t w;
        w = '0;
        if (idx < 32'(NUM_OF_WORDS)) begin
            w = rd;
        end else if (idx == 32'(NUM_OF_WORDS)) begin
            w = SHA256_PAD_WORD;
        end else if (idx == 32'(TOTAL_WORDS - 1)) begin
            w = LEN_WORD;
        end
        return w;
    endfunction

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    assign cur_idx     = {12'b0, blk_q, 4'b0} + {27'b0, k_q};
    assign wr_idx      = cur_idx - 32'd1;
    assign nxt_idx     = cur_idx + 32'd1;
    assign blk_inc     = blk_q + 16'd1;
    assign nxt_blk_idx = {12'b0, blk_inc, 4'b0};
    // Slot s lives at bits [(15-s)*32 +: 32]; ~s is 15-s for a 4-bit slot.
    assign wr_slot     = 4'(k_q - 5'd1);
    assign wr_pos      = {~wr_slot, 5'b0};
    assign is_last     = (blk_q == 16'(BLOCKS - 1));
    assign fill_end    = (k_q == 5'(SHA256_BLOCK_WORDS));

    // Next-state selection; the handshake is only meaningful while offering.
    always_comb begin
        state_d   = state_q;
        handshake = 1'b0;
        case (state_q)
            PAD_IDLE: begin
                if (start) state_d = PAD_FILL;
            end
            PAD_FILL: begin
                if (fill_end) state_d = PAD_OFFER;
            end
            PAD_OFFER: begin
                if (blk_ready) begin
                    handshake = 1'b1;
                    state_d   = is_last ? PAD_DONE : PAD_FILL;
                end
            end
            PAD_DONE: begin
                state_d = PAD_IDLE;
            end
            default: state_d = PAD_IDLE;
        endcase
    end

    // State register plus the fetch/assemble datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PAD_IDLE;
            base_q    <= '0;
            blk_q     <= '0;
            k_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            blk_data  <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            blk_index <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                PAD_IDLE: begin
                    if (start) begin
                        base_q   <= message_addr;
                        blk_q    <= '0;
                        k_q      <= '0;
                        busy     <= 1'b1;
                        // Word 0 always exists, so its read goes out in fill cycle 0.
                        mem_addr <= message_addr;
                    end
                end
                PAD_FILL: begin
                    // Data for the address presented last cycle arrives now.
                    if (k_q != 5'd0) begin
                        blk_data[wr_pos +: 32] <= slot_word(wr_idx, mem_read_data);
                    end
                    if ((k_q < 5'd15) && (nxt_idx < 32'(NUM_OF_WORDS))) begin
                        mem_addr <= base_q + nxt_idx[15:0];
                    end
                    if (fill_end) begin
                        k_q       <= '0;
                        blk_valid <= 1'b1;
                        blk_last  <= is_last;
                        blk_index <= blk_q[7:0];
                    end else begin
                        k_q <= k_q + 5'd1;
                    end
                end
                PAD_OFFER: begin
                    if (handshake) begin
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        if (!is_last) begin
                            blk_q <= blk_inc;
                            k_q   <= '0;
                            if (nxt_blk_idx < 32'(NUM_OF_WORDS)) begin
                                mem_addr <= base_q + nxt_blk_idx[15:0];
                            end
                        end
                    end
                end
                PAD_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: four instances (40, 13, 14, 4 words), scoreboard on block handshakes.
// Latency: checks first-valid and start-to-done cycle counts against the padding block count.
// Backpressure: stalls one block and checks it stays bit-stable until accepted.
module tb_sha256_msg_padder;

    typedef struct packed {
        logic [511:0] d;
        logic [7:0]   idx;
        logic         last;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [15:0]  message_addr;
    logic         start     [4];
    logic         busy      [4];
    logic         done      [4];
    logic         mem_clk   [4];
    logic         mem_we    [4];
    logic [15:0]  mem_addr  [4];
    logic [511:0] blk_data  [4];
    logic         blk_valid [4];
    logic         blk_ready [4];
    logic         blk_last  [4];
    logic [7:0]   blk_index [4];

    int           total = 0;
    int           bad   = 0;
    int           sel   = 0;
    exp_t         sb[$];
    logic [511:0] rx[$];
    bit           rx_last[$];
    logic [15:0]  addr_q[$];
    logic [511:0] prev_data;
    logic [7:0]   prev_idx;
    logic         prev_last;
    bit           have_prev = 0;

    function automatic int nw_of(input int g);
        case (g)
            0:       return 40;
            1:       return 13;
            2:       return 14;
            default: return 4;
        endcase
    endfunction

    // Memory contents: 0x01234675 at word 0, rotated left by one per word.
    function automatic logic [31:0] memval(input logic [15:0] a);
        logic [31:0] s;
        logic [4:0]  r;
        s = 32'h0123_4675;
        r = a[4:0];
        if (r == 5'd0) return s;
        return (s << r) | (s >> (6'd32 - {1'b0, r}));
    endfunction

    function automatic logic [31:0] word_of(input logic [511:0] b, input int w);
        return b[511 - 32*w -: 32];
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NW = nw_of(g);
        logic [31:0] rd;

        // One-cycle-latency word memory.
        always @(posedge clk) rd <= memval(mem_addr[g]);

        sha256_msg_padder #(.NUM_OF_WORDS(NW)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start[g]),
            .message_addr (message_addr),
            .busy         (busy[g]),
            .done         (done[g]),
            .mem_clk      (mem_clk[g]),
            .mem_we       (mem_we[g]),
            .mem_addr     (mem_addr[g]),
            .mem_read_data(rd),
            .blk_data     (blk_data[g]),
            .blk_valid    (blk_valid[g]),
            .blk_ready    (blk_ready[g]),
            .blk_last     (blk_last[g]),
            .blk_index    (blk_index[g])
        );
    end

    // Scoreboard: stability while stalled, compare on each handshake.
    always @(negedge clk) begin
        if (!reset && blk_valid[sel]) begin
            if (have_prev) begin
                chk("hold_data", blk_data[sel], prev_data);
                chk("hold_index", 512'(blk_index[sel]), 512'(prev_idx));
                chk("hold_last", 512'(blk_last[sel]), 512'(prev_last));
            end
            if (blk_ready[sel]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_block", 512'(1), 512'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("blk_data", blk_data[sel], e.d);
                    chk("blk_index", 512'(blk_index[sel]), 512'(e.idx));
                    chk("blk_last", 512'(blk_last[sel]), 512'(e.last));
                end
                rx.push_back(blk_data[sel]);
                rx_last.push_back(blk_last[sel]);
                have_prev = 0;
            end else begin
                prev_data = blk_data[sel];
                prev_idx  = blk_index[sel];
                prev_last = blk_last[sel];
                have_prev = 1;
            end
        end else begin
            have_prev = 0;
        end
    end

    // Address trace: each new read address issued while busy.
    always @(negedge clk) begin
        if (!reset && busy[sel]) begin
            if (addr_q.size() == 0 || mem_addr[sel] != addr_q[$]) addr_q.push_back(mem_addr[sel]);
        end
    end

    // Reference padding: message, 0x80000000, zeros, 64-bit bit length.
    task automatic push_exp(input int g, input logic [15:0] addr);
        int nw;
        int nb;
        nw = nw_of(g);
        nb = (nw + 3 + 15) / 16;
        for (int b = 0; b < nb; b++) begin
            exp_t e;
            e.d = '0;
            for (int w = 0; w < 16; w++) begin
                int i;
                logic [31:0] v;
                i = b*16 + w;
                if (i < nw)              v = memval(addr + 16'(i));
                else if (i == nw)        v = 32'h8000_0000;
                else if (i == nb*16 - 1) v = 32'(nw * 32);
                else                     v = 32'h0;
                e.d[511 - 32*w -: 32] = v;
            end
            e.idx  = 8'(b);
            e.last = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    task automatic chk_reset_state(input int g);
        chk("rst_busy", 512'(busy[g]), 512'(0));
        chk("rst_done", 512'(done[g]), 512'(0));
        chk("rst_mem_addr", 512'(mem_addr[g]), 512'(0));
        chk("rst_blk_data", blk_data[g], 512'(0));
        chk("rst_blk_valid", 512'(blk_valid[g]), 512'(0));
        chk("rst_blk_last", 512'(blk_last[g]), 512'(0));
        chk("rst_blk_index", 512'(blk_index[g]), 512'(0));
    endtask

    task automatic run(input int g, input logic [15:0] addr, input bit bp);
        int  nb;
        int  cnt;
        int  first_vld;
        int  hold;
        bit  bp_started;
        bit  bp_done;
        bit  seen_done;
        nb = (nw_of(g) + 3 + 15) / 16;
        sel = g;
        rx.delete();
        rx_last.delete();
        addr_q.delete();
        push_exp(g, addr);
        @(posedge clk); #1;
        message_addr = addr;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 512'(busy[g]), 512'(1));
        cnt = 0; first_vld = -1; hold = 0;
        bp_started = 0; bp_done = 0; seen_done = 0;
        while (cnt < 3000) begin
            @(posedge clk);
            cnt++;
            #1;
            if (bp) begin
                if (!bp_started && rx.size() == 1) begin
                    blk_ready[g] = 1'b0;
                    bp_started = 1;
                end else if (bp_started && !bp_done && blk_valid[g]) begin
                    hold++;
                    if (hold == 6) begin
                        blk_ready[g] = 1'b1;
                        bp_done = 1;
                    end
                end
            end
            @(negedge clk);
            if (first_vld < 0 && blk_valid[g]) first_vld = cnt;
            if (done[g]) begin
                seen_done = 1;
                break;
            end
        end
        blk_ready[g] = 1'b1;
        chk("done_seen", 512'(seen_done), 512'(1));
        chk("first_valid_latency", 512'(first_vld), 512'(17));
        chk("start_to_done", 512'(cnt), 512'(nb*18 + 1 + (bp ? 5 : 0)));
        chk("busy_at_done", 512'(busy[g]), 512'(0));
        @(negedge clk);
        chk("done_pulse_width", 512'(done[g]), 512'(0));
        chk("blocks_received", 512'(rx.size()), 512'(nb));
        chk("scoreboard_drained", 512'(sb.size()), 512'(0));
    endtask

    initial begin
        reset = 1'b1;
        message_addr = '0;
        for (int g = 0; g < 4; g++) begin
            start[g] = 1'b0;
            blk_ready[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state(0);
        chk("mem_we", 512'(mem_we[0]), 512'(0));
        reset = 1'b0;

        // 40 words, free-flowing consumer.
        run(0, 16'h0000, 0);
        if (rx.size() == 3) begin
            chk("n40_b0w0", 512'(word_of(rx[0], 0)), 512'(32'h0123_4675));
            chk("n40_b0w1", 512'(word_of(rx[0], 1)), 512'(32'h0246_8CEA));
            chk("n40_b2w8", 512'(word_of(rx[2], 8)), 512'(32'h8000_0000));
            chk("n40_b2w15", 512'(word_of(rx[2], 15)), 512'(32'h0000_0500));
            chk("n40_last_pattern", 512'({rx_last[0], rx_last[1], rx_last[2]}), 512'(3'b001));
        end

        // 13 words: pad and length fit in one block.
        run(1, 16'h0000, 0);
        if (rx.size() == 1) begin
            chk("n13_w13", 512'(word_of(rx[0], 13)), 512'(32'h8000_0000));
            chk("n13_w14", 512'(word_of(rx[0], 14)), 512'(0));
            chk("n13_w15", 512'(word_of(rx[0], 15)), 512'(32'h0000_01A0));
            chk("n13_last", 512'(rx_last[0]), 512'(1));
        end

        // 14 words: length spills into a second, otherwise empty block.
        run(2, 16'h0000, 0);
        if (rx.size() == 2) begin
            chk("n14_b0w14", 512'(word_of(rx[0], 14)), 512'(32'h8000_0000));
            chk("n14_b0w15", 512'(word_of(rx[0], 15)), 512'(0));
            chk("n14_b1_zero", 512'(rx[1][511:32]), 512'(0));
            chk("n14_b1w15", 512'(word_of(rx[1], 15)), 512'(32'h0000_01C0));
        end

        // 40 words with block 1 stalled for 5 cycles.
        run(0, 16'h0000, 1);

        // Address wrap at the top of the 16-bit space.
        run(3, 16'hFFFE, 0);
        chk("wrap_reads", 512'(addr_q.size()), 512'(4));
        if (addr_q.size() == 4) begin
            chk("wrap_a0", 512'(addr_q[0]), 512'(16'hFFFE));
            chk("wrap_a1", 512'(addr_q[1]), 512'(16'hFFFF));
            chk("wrap_a2", 512'(addr_q[2]), 512'(16'h0000));
            chk("wrap_a3", 512'(addr_q[3]), 512'(16'h0001));
        end

        // Reset during fill cycle 7 of block 1, then a clean rerun.
        sel = 0;
        rx.delete();
        rx_last.delete();
        push_exp(0, 16'h0000);
        @(posedge clk); #1;
        message_addr = 16'h0000;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int c = 1; c <= 25; c++) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_state(0);
        reset = 1'b0;
        sb.delete();
        begin
            logic any;
            any = 1'b0;
            repeat (40) begin
                @(negedge clk);
                any = any | done[0] | blk_valid[0] | busy[0];
            end
            chk("quiet_after_reset", 512'(any), 512'(0));
        end
        run(0, 16'h0000, 0);
        if (rx.size() == 3) begin
            chk("rerun_b0w0", 512'(word_of(rx[0], 0)), 512'(32'h0123_4675));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
